// File: rtl/jpeg_drain_pkg.sv
// Shared types and constants for the JPEG FIFO drain (byte serializer).
package jpeg_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_LOAD = 2'd2,
    ST_SEND = 2'd3
  } drain_state_t;

  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] JPEG_EOI_CODE      = 8'hD9;
  localparam int         BYTES_PER_WORD     = 4;
  localparam logic [1:0] LAST_BYTE_IDX      = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/jpeg_eoi_detect.sv
// Remembers the last byte handed to the sink and flags an FF->D9 end-of-image
// pair; the history spans word boundaries because it only advances on transfers.
module jpeg_eoi_detect
  import jpeg_drain_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       xfer_i,
  input  logic [7:0] byte_i,
  output logic       match_o
);

  logic [7:0] prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 8'h00;
    end else if (clear_i) begin
      prev_q <= 8'h00;
    end else if (xfer_i) begin
      prev_q <= byte_i;
    end
  end

  assign match_o = (prev_q == JPEG_MARKER_PREFIX) && (byte_i == JPEG_EOI_CODE);

endmodule

// File: rtl/jpeg_fifo_drain.sv
// Pops 32-bit words from the JPEG output FIFO and streams them MSB byte first.
// Define JPEG_DRAIN_EOI_DETECT_EN to end frames on FF D9 and drop word padding.
module jpeg_fifo_drain
  import jpeg_drain_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_CNT_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_i,
  input  logic [DATA_WIDTH-1:0]     fifo_data_i,
  input  logic                      fifo_empty_i,
  output logic                      fifo_rd_o,
  output logic [7:0]                byte_o,
  output logic                      byte_valid_o,
  input  logic                      byte_ready_i,
  output logic                      byte_last_o,
  output logic                      eoi_o,
  output logic [BYTE_CNT_WIDTH-1:0] byte_cnt_o,
  output logic                      busy_o
);

  drain_state_t              state_q, state_nxt;
  logic [DATA_WIDTH-1:0]     word_q;
  logic [1:0]                idx_q;
  logic [BYTE_CNT_WIDTH-1:0] cnt_q;
  logic                      xfer;
  logic                      last_byte;
  logic                      word_done;
  logic                      cnt_clr;

  assign xfer      = byte_valid_o & byte_ready_i;
  assign word_done = xfer & ((idx_q == LAST_BYTE_IDX) | last_byte);

`ifdef JPEG_DRAIN_EOI_DETECT_EN
  logic eoi_match;
  logic eoi_q;

  jpeg_eoi_detect u_eoi_detect (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear_i),
    .xfer_i  (xfer),
    .byte_i  (byte_o),
    .match_o (eoi_match)
  );

  assign last_byte = eoi_match & byte_valid_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eoi_q <= 1'b0;
    end else if (clear_i) begin
      eoi_q <= 1'b0;
    end else begin
      eoi_q <= xfer & last_byte;
    end
  end

  assign eoi_o   = eoi_q;
  assign cnt_clr = eoi_q;
`else
  assign last_byte = 1'b0;
  assign eoi_o     = 1'b0;
  assign cnt_clr   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: if (!fifo_empty_i) state_nxt = ST_POP;
      // Only this block pops, so empty cannot rise here; the guard is defensive.
      ST_POP:  state_nxt = fifo_empty_i ? ST_IDLE : ST_LOAD;
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: if (word_done) state_nxt = fifo_empty_i ? ST_IDLE : ST_POP;
      default: state_nxt = ST_IDLE;
    endcase
    if (clear_i) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      idx_q  <= 2'd0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      idx_q <= 2'd0;
      cnt_q <= '0;
    end else begin
      if (state_q == ST_LOAD) begin
        word_q <= fifo_data_i;
        idx_q  <= 2'd0;
      end else if (xfer) begin
        word_q <= {word_q[DATA_WIDTH-9:0], 8'h00};
        idx_q  <= idx_q + 2'd1;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (xfer) begin
        cnt_q <= cnt_q + BYTE_CNT_WIDTH'(1);
      end
    end
  end

  assign fifo_rd_o    = (state_q == ST_POP) & ~fifo_empty_i & ~clear_i;
  assign byte_o       = word_q[DATA_WIDTH-1 -: 8];
  assign byte_valid_o = (state_q == ST_SEND);
  assign byte_last_o  = last_byte;
  assign byte_cnt_o   = cnt_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule
